// File: rtl/x_val_pairing.sv
// x_val_pairing
//   Pairs the x-element stream coming out of x_vector_cache with the matrix
//   nonzero stream from the value reader. Each stream is held in its own
//   FIFO; whenever both heads are present and the multiply-accumulate stage
//   is not stalling, one aligned (x, a, last) triple is emitted.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   push_x, x_val     x element write (no backpressure, pulse per value)
//   push_val, val_in,
//   val_last          matrix value write with row-end marker
//   x_stall           x FIFO occupancy at/above the stall threshold
//   val_stall         value FIFO occupancy at/above the stall threshold
//   pair_stall        downstream refuses a new pair this cycle
//   pair_push         one-cycle valid for pair_x / pair_val / pair_last
//   row_count         pairs emitted with pair_last set since reset
//   overflow_err      sticky: a push hit a full FIFO and was dropped
module x_val_pairing #(
   parameter int DEPTH        = 16,
   parameter int LOG2_DEPTH   = $clog2(DEPTH),
   parameter int STALL_MARGIN = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_x,
   input  logic [63:0] x_val,
   input  logic        push_val,
   input  logic [63:0] val_in,
   input  logic        val_last,
   output logic        x_stall,
   output logic        val_stall,
   input  logic        pair_stall,
   output logic        pair_push,
   output logic [63:0] pair_x,
   output logic [63:0] pair_val,
   output logic        pair_last,
   output logic [31:0] row_count,
   output logic        overflow_err
);

   localparam int PW = LOG2_DEPTH;
   localparam int CW = LOG2_DEPTH + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_MARGIN);

   logic [63:0]   x_mem_q [DEPTH];
   logic [64:0]   v_mem_q [DEPTH];

   logic [PW-1:0] x_wp_q, x_wp_d, x_rp_q, x_rp_d;
   logic [PW-1:0] v_wp_q, v_wp_d, v_rp_q, v_rp_d;
   logic [CW-1:0] x_count_q, x_count_d, v_count_q, v_count_d;
   logic          x_stall_q, x_stall_d, val_stall_q, val_stall_d;
   logic          pair_push_q, pair_push_d, pair_last_q, pair_last_d;
   logic [63:0]   pair_x_q, pair_x_d, pair_val_q, pair_val_d;
   logic [31:0]   row_count_q, row_count_d;
   logic          overflow_q, overflow_d;
   logic          pop, x_wr, v_wr;

   always_comb begin
      pop  = (x_count_q != '0) && (v_count_q != '0) && !pair_stall;
      // A full FIFO still accepts a write when its head leaves in the same
      // cycle: the head is read from the pre-edge array, the write lands at
      // the edge into the slot being vacated.
      x_wr = push_x   && ((x_count_q != FULL_CNT) || pop);
      v_wr = push_val && ((v_count_q != FULL_CNT) || pop);

      x_wp_d    = x_wr ? x_wp_q + PW'(1) : x_wp_q;
      v_wp_d    = v_wr ? v_wp_q + PW'(1) : v_wp_q;
      x_rp_d    = pop  ? x_rp_q + PW'(1) : x_rp_q;
      v_rp_d    = pop  ? v_rp_q + PW'(1) : v_rp_q;
      x_count_d = x_count_q + CW'(x_wr) - CW'(pop);
      v_count_d = v_count_q + CW'(v_wr) - CW'(pop);

      x_stall_d   = (x_count_d >= STALL_CNT);
      val_stall_d = (v_count_d >= STALL_CNT);
      overflow_d  = overflow_q || (push_x && !x_wr) || (push_val && !v_wr);

      pair_push_d = pop;
      pair_x_d    = pair_x_q;
      pair_val_d  = pair_val_q;
      pair_last_d = pair_last_q;
      if (pop) begin
         pair_x_d    = x_mem_q[x_rp_q];
         pair_val_d  = v_mem_q[v_rp_q][63:0];
         pair_last_d = v_mem_q[v_rp_q][64];
      end

      row_count_d = row_count_q + ((pair_push_q && pair_last_q) ? 32'd1 : 32'd0);
   end

   // Storage needs no reset: pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (x_wr) x_mem_q[x_wp_q] <= x_val;
      if (v_wr) v_mem_q[v_wp_q] <= {val_last, val_in};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_wp_q      <= '0;
         x_rp_q      <= '0;
         v_wp_q      <= '0;
         v_rp_q      <= '0;
         x_count_q   <= '0;
         v_count_q   <= '0;
         x_stall_q   <= 1'b0;
         val_stall_q <= 1'b0;
         pair_push_q <= 1'b0;
         pair_x_q    <= '0;
         pair_val_q  <= '0;
         pair_last_q <= 1'b0;
         row_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         x_wp_q      <= x_wp_d;
         x_rp_q      <= x_rp_d;
         v_wp_q      <= v_wp_d;
         v_rp_q      <= v_rp_d;
         x_count_q   <= x_count_d;
         v_count_q   <= v_count_d;
         x_stall_q   <= x_stall_d;
         val_stall_q <= val_stall_d;
         pair_push_q <= pair_push_d;
         pair_x_q    <= pair_x_d;
         pair_val_q  <= pair_val_d;
         pair_last_q <= pair_last_d;
         row_count_q <= row_count_d;
         overflow_q  <= overflow_d;
      end
   end

   assign x_stall      = x_stall_q;
   assign val_stall    = val_stall_q;
   assign pair_push    = pair_push_q;
   assign pair_x       = pair_x_q;
   assign pair_val     = pair_val_q;
   assign pair_last    = pair_last_q;
   assign row_count    = row_count_q;
   assign overflow_err = overflow_q;

endmodule

// File: doc/x_val_pairing.md
Name: x_val_pairing

Overview:
- Sits directly downstream of x_vector_cache in the SpMV PE.
- Buffers the x_val stream from the cache (push_x/x_val, no backpressure) and the matrix value stream from the value reader (push_val/val_in/val_last).
- Emits one aligned (x, a, last) triple per nonzero to the multiply-accumulate stage.
- Raises stall outputs early enough to absorb requests already in flight upstream.

Parameters:
- DEPTH, 16, entries in each internal FIFO; must be a power of two, at least 4.
- LOG2_DEPTH, log2(DEPTH-1) via common.vh (4 at default), FIFO pointer width.
- STALL_MARGIN, 6, free-slot margin: stall asserts when count >= DEPTH - STALL_MARGIN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; the block is in reset while rst == 0.
- push_x  in  1  x value valid; one-cycle pulse per value, from x_vector_cache.
- x_val  in  64  x vector element, captured when push_x == 1.
- push_val  in  1  matrix value valid.
- val_in  in  64  matrix nonzero value.
- val_last  in  1  marks the last nonzero of a row; captured with val_in.
- x_stall  out  1  upstream must stop push_col to the cache.
- val_stall  out  1  value reader must stop pushing.
- pair_stall  in  1  downstream cannot accept a pair this cycle.
- pair_push  out  1  one-cycle pulse; pair_x, pair_val and pair_last are valid.
- pair_x  out  64  x operand.
- pair_val  out  64  matrix operand.
- pair_last  out  1  row-end marker travelling with the pair.
- row_count  out  32  number of pairs emitted with pair_last == 1 since reset.
- overflow_err  out  1  sticky; a push arrived at a full FIFO.

Behaviour:
- Reset (rst == 0, asynchronous):
  - Both FIFOs emptied; pointers and counts are 0.
  - pair_push = 0, pair_x = 0, pair_val = 0, pair_last = 0.
  - row_count = 0, overflow_err = 0, x_stall = 0, val_stall = 0.
  - Reset asserted mid-operation discards all buffered entries and any pending pair immediately; no pair_push is issued after reset releases until new data arrives.
- Two independent FIFOs:
  - X FIFO, 64 bits wide.
  - V FIFO, 65 bits wide ({val_last, val_in}).
  - Each has a count register LOG2_DEPTH+1 bits wide.
  - Write on push_x / push_val at the clock edge.
  - Entries are visible to the pop logic on the following cycle; there is no same-cycle fall-through.
- Pop rule, evaluated each cycle:
  - pop = (x_count != 0) && (v_count != 0) && !pair_stall.
  - On pop, both FIFOs advance together.
  - The registered outputs load the head entries, and pair_push = 1 in the next cycle.
  - Otherwise pair_push = 0, and pair_x/pair_val/pair_last hold their last values.
- Latency: when both FIFOs are empty, the pushes that complete a pair, sampled at edge N, produce pair_push high in the cycle following edge N+1, i.e. 2 cycles.
- Throughput: one pair per cycle while both FIFOs are non-empty and pair_stall == 0.
- pair_stall is combinational into the pop decision only. A pair already issued (pair_push high) is not retracted.
- Write acceptance: a push is accepted if count < DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop leaves the count unchanged.
- Overflow: a push to a full FIFO without a same-cycle pop is dropped and sets overflow_err = 1. overflow_err stays set until reset.
- Stall flags:
  - x_stall = (x_count >= DEPTH - STALL_MARGIN), registered from the next count.
  - val_stall uses the same rule on v_count.
  - Both deassert as soon as the count falls below the threshold.
- Pointer wrap: pointers wrap modulo DEPTH. Count distinguishes full (DEPTH) from empty (0).
- row_count increments by 1 in the cycle pair_push == 1 && pair_last == 1. It wraps at 2^32.
- x_val and val_in are opaque 64-bit data; they are not interpreted as floating point.

Test Plan:
- Single pair: push_x with x_val = 5 at edge 1, push_val with val_in = 7 and val_last = 1 at edge 3 -> pair_push = 1 in the cycle after edge 4 only, with pair_x = 5, pair_val = 7, pair_last = 1, and row_count = 1.
- Streaming: 8 cycles of simultaneous pushes with x = i, val = 100+i, last only on i = 7 -> 8 consecutive pair_push pulses starting 2 cycles after the first push, in order, row_count = 1.
- Backpressure and stall: pair_stall = 1 while pushing 10 x values and 10 val values -> no pair_push. x_stall and val_stall assert once count reaches 10 (DEPTH 16, margin 6). Release pair_stall -> 10 pairs emitted in order, and the stall flags clear when count < 10.
- Overflow: pair_stall = 1, push 17 x values -> count stays 16, overflow_err = 1, and value 16 is dropped. Release stall with 16 vals -> pairs x = 0..15.
- Full with simultaneous push and pop: X FIFO full, V FIFO non-empty, pair_stall = 0, push_x the same cycle -> accepted, overflow_err stays 0, count stays 16.
- Mid-operation reset: 3 pairs buffered, rst = 0 for one cycle -> all outputs return to 0 immediately. After release, no pair_push until new pushes arrive, and the first pair after release carries the new values.
